pci_param_arbiter: RTL and testbench

- Central PCI bus arbiter for NUM_MASTERS requesters, replacing the fixed three-master arbiter.
- Selectable fixed-priority or round-robin arbitration.
- Enforces a one-cycle turnaround between different owners.
- Revokes grants that are never used, and supports optional bus parking.
- Sits beside the DEVICE instances; drives each device's active-low GNT and samples the shared FRAME/IRDY.

---
 rtl/pci_param_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_pci_param_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pci_param_arbiter.sv
// pci_param_arbiter: central PCI arbiter, fixed-priority or round-robin, with grant timeout.
// Optional bus parking on the last owner when PCI_ARB_PARK_EN is defined. Rev 1.0
`default_nettype none

module pci_param_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int ARB_MODE    = 1,
  parameter int GNT_TIMEOUT = 16,
  parameter int ID_W        = 2
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic [NUM_MASTERS-1:0] req_n,
  input  logic                   frame_n,
  input  logic                   irdy_n,
  output logic [NUM_MASTERS-1:0] gnt_n,
  output logic [ID_W-1:0]        gnt_id,
  output logic                   gnt_valid,
  output logic                   bus_busy,
  output logic                   timeout_pulse
);

`ifdef PCI_ARB_PARK_EN
  localparam logic c_PARK = 1'b1;
`else
  localparam logic c_PARK = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_BUSY  = 2'd2,
    S_TURN  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_nxt_state;
  logic [NUM_MASTERS-1:0] r_gnt_n;
  logic [NUM_MASTERS-1:0] w_nxt_gnt_n;
  logic [ID_W-1:0]        r_gnt_id;
  logic [ID_W-1:0]        w_nxt_id;
  logic [ID_W-1:0]        r_rr_ptr;
  logic [ID_W-1:0]        w_nxt_rr;
  logic [7:0]             r_wait_cnt;
  logic [7:0]             w_nxt_cnt;
  logic                   r_gnt_valid;
  logic                   r_bus_busy;
  logic                   r_timeout;
  logic                   w_nxt_timeout;
  logic                   w_do_grant;

  logic [NUM_MASTERS-1:0] w_req;
  logic [NUM_MASTERS-1:0] w_owner_mask;
  logic                   w_any_req;
  logic                   w_owner_req;
  logic                   w_other_req;
  logic                   w_bus_idle;
  logic [ID_W-1:0]        w_win_id;

  function automatic logic [NUM_MASTERS-1:0] f_onehot(input logic [ID_W-1:0] id);
    logic [NUM_MASTERS-1:0] m;
    m = '0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      m[j] = (id == ID_W'(j));
    end
    return m;
  endfunction

  function automatic logic [ID_W-1:0] f_next_ptr(input logic [ID_W-1:0] k);
    if (k == ID_W'(NUM_MASTERS - 1)) begin
      return '0;
    end
    return k + ID_W'(1);
  endfunction

  assign w_req        = ~req_n;
  assign w_owner_mask = f_onehot(r_gnt_id);
  assign w_any_req    = |w_req;
  assign w_owner_req  = |(w_req & w_owner_mask);
  assign w_other_req  = |(w_req & ~w_owner_mask);
  assign w_bus_idle   = frame_n & irdy_n;

  // Walk candidates from lowest to highest priority so the last hit is the winner.
  always_comb begin : p_winner
    int v_idx;
    w_win_id = '0;
    v_idx    = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      v_idx = (ARB_MODE == 1) ? int'(r_rr_ptr) + i : i;
      if (v_idx >= NUM_MASTERS) begin
        v_idx = v_idx - NUM_MASTERS;
      end
      for (int j = 0; j < NUM_MASTERS; j++) begin
        if ((j == v_idx) && w_req[j]) begin
          w_win_id = ID_W'(j);
        end
      end
    end
  end

  always_comb begin : p_fsm
    w_nxt_state   = r_state;
    w_nxt_id      = r_gnt_id;
    w_nxt_rr      = r_rr_ptr;
    w_nxt_cnt     = r_wait_cnt;
    w_nxt_timeout = 1'b0;
    w_do_grant    = 1'b0;
    w_nxt_gnt_n   = '1;

    case (r_state)
      S_IDLE: begin
        w_nxt_cnt = '0;
        if (c_PARK) begin
          if (!frame_n) begin
            w_nxt_state = S_BUSY;
          end else if (w_any_req) begin
            if (w_win_id == r_gnt_id) begin
              w_do_grant = 1'b1;
            end else begin
              w_nxt_state = S_TURN;
            end
          end
        end else if (w_any_req) begin
          w_do_grant = 1'b1;
        end
      end

      S_TURN: begin
        w_nxt_cnt = '0;
        if (w_any_req) begin
          w_do_grant = 1'b1;
        end else begin
          w_nxt_state = S_IDLE;
        end
      end

      S_GRANT: begin
        if (!frame_n) begin
          w_nxt_state = S_BUSY;
        end else if (!w_owner_req) begin
          w_nxt_state = w_other_req ? S_TURN : S_IDLE;
        end else if (r_wait_cnt >= 8'(GNT_TIMEOUT)) begin
          w_nxt_state   = S_TURN;
          w_nxt_timeout = 1'b1;
        end else begin
          w_nxt_cnt = r_wait_cnt + 8'd1;
        end
      end

      S_BUSY: begin
        w_nxt_cnt = '0;
        if (w_bus_idle) begin
          // A lone owner request means the winner is the owner itself.
          if (w_owner_req && !w_other_req) begin
            w_do_grant = 1'b1;
          end else begin
            w_nxt_state = S_TURN;
          end
        end
      end

      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase

    if (w_do_grant) begin
      w_nxt_state = S_GRANT;
      w_nxt_id    = w_win_id;
      w_nxt_rr    = f_next_ptr(w_win_id);
      w_nxt_cnt   = 8'd1;
    end

    if ((w_nxt_state == S_GRANT) || (w_nxt_state == S_BUSY) ||
        (c_PARK && (w_nxt_state == S_IDLE))) begin
      w_nxt_gnt_n = ~f_onehot(w_nxt_id);
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      r_state     <= S_IDLE;
      r_gnt_n     <= '1;
      r_gnt_id    <= '0;
      r_rr_ptr    <= '0;
      r_wait_cnt  <= '0;
      r_gnt_valid <= 1'b0;
      r_bus_busy  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_gnt_n     <= w_nxt_gnt_n;
      r_gnt_id    <= w_nxt_id;
      r_rr_ptr    <= w_nxt_rr;
      r_wait_cnt  <= w_nxt_cnt;
      r_gnt_valid <= ~&w_nxt_gnt_n;
      r_bus_busy  <= (w_nxt_state == S_BUSY);
      r_timeout   <= w_nxt_timeout;
    end
  end

  assign gnt_n         = r_gnt_n;
  assign gnt_id        = r_gnt_id;
  assign gnt_valid     = r_gnt_valid;
  assign bus_busy      = r_bus_busy;
  assign timeout_pulse = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_pci_param_arbiter.sv
// Directed testbench for pci_param_arbiter: round-robin instance plus a fixed-priority instance.
`default_nettype none

module tb_pci_param_arbiter;
  logic       clk = 1'b0;
  logic       RESET;
  logic [2:0] req_n;
  logic       frame_n;
  logic       irdy_n;

  logic [2:0] gnt_n, gnt_n_fp;
  logic [1:0] gnt_id, gnt_id_fp;
  logic       gnt_valid, bus_busy, timeout_pulse;
  logic       gv_fp, bb_fp, tp_fp;

  int vec  = 0;
  int errs = 0;

  // {gnt_n, gnt_id, gnt_valid, bus_busy, timeout_pulse}
  wire [7:0] obs    = {gnt_n, gnt_id, gnt_valid, bus_busy, timeout_pulse};
  wire [7:0] obs_fp = {gnt_n_fp, gnt_id_fp, gv_fp, bb_fp, tp_fp};

  pci_param_arbiter #(.NUM_MASTERS(3), .ARB_MODE(1), .GNT_TIMEOUT(16), .ID_W(2)) dut (
    .clk(clk), .RESET(RESET), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .gnt_n(gnt_n), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .bus_busy(bus_busy),
    .timeout_pulse(timeout_pulse)
  );

  pci_param_arbiter #(.NUM_MASTERS(3), .ARB_MODE(0), .GNT_TIMEOUT(16), .ID_W(2)) dut_fp (
    .clk(clk), .RESET(RESET), .req_n(req_n), .frame_n(frame_n), .irdy_n(irdy_n),
    .gnt_n(gnt_n_fp), .gnt_id(gnt_id_fp), .gnt_valid(gv_fp), .bus_busy(bb_fp),
    .timeout_pulse(tp_fp)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET   = 1'b0;
    req_n   = 3'b111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    step();
    RESET = 1'b1;
  endtask

  task automatic test_reset();
    RESET   = 1'b0;
    req_n   = 3'b111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    if (obs !== 8'b111_00_000) begin
      errs++; $display("FAIL reset_rr: got %b exp %b", obs, 8'b111_00_000);
    end
    vec++;
    if (obs_fp !== 8'b111_00_000) begin
      errs++; $display("FAIL reset_fp: got %b exp %b", obs_fp, 8'b111_00_000);
    end
    vec++;
    RESET = 1'b1;
    step();
`ifdef PCI_ARB_PARK_EN
    if (obs !== 8'b110_00_100) begin
      errs++; $display("FAIL reset_park: got %b exp %b", obs, 8'b110_00_100);
    end
`else
    if (obs !== 8'b111_00_000) begin
      errs++; $display("FAIL reset_idle: got %b exp %b", obs, 8'b111_00_000);
    end
`endif
    vec++;
  endtask

  task automatic test_single();
    do_reset();
    req_n = 3'b110;
    step();
    if (obs !== 8'b110_00_100) begin
      errs++; $display("FAIL single_grant: got %b exp %b", obs, 8'b110_00_100);
    end
    vec++;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (obs !== 8'b110_00_110) begin
        errs++; $display("FAIL single_busy[%0d]: got %b exp %b", i, obs, 8'b110_00_110);
      end
      vec++;
    end
    frame_n = 1'b1;
    req_n   = 3'b111;
    step();
    if (obs !== 8'b110_00_110) begin
      errs++; $display("FAIL single_last_data: got %b exp %b", obs, 8'b110_00_110);
    end
    vec++;
    irdy_n = 1'b1;
    step();
    if (obs !== 8'b111_00_000) begin
      errs++; $display("FAIL single_turn: got %b exp %b", obs, 8'b111_00_000);
    end
    vec++;
    step();
    if (obs !== 8'b111_00_000) begin
      errs++; $display("FAIL single_idle: got %b exp %b", obs, 8'b111_00_000);
    end
    vec++;
  endtask

  task automatic test_round_robin();
    int         own [4] = '{0, 1, 2, 0};
    logic [2:0] eg;
    logic [1:0] eid;
    do_reset();
    req_n = 3'b000;
    for (int n = 0; n < 4; n++) begin
      eg  = ~(3'b001 << own[n]);
      eid = 2'(own[n]);
      step();
      if (obs !== {eg, eid, 3'b100}) begin
        errs++; $display("FAIL rr_grant[%0d]: got %b exp %b", n, obs, {eg, eid, 3'b100});
      end
      vec++;
      frame_n = 1'b0;
      irdy_n  = 1'b0;
      step();
      if (obs !== {eg, eid, 3'b110}) begin
        errs++; $display("FAIL rr_busy[%0d]: got %b exp %b", n, obs, {eg, eid, 3'b110});
      end
      vec++;
      frame_n = 1'b1;
      irdy_n  = 1'b1;
      step();
      if (obs !== {3'b111, eid, 3'b000}) begin
        errs++; $display("FAIL rr_turn[%0d]: got %b exp %b", n, obs, {3'b111, eid, 3'b000});
      end
      vec++;
    end
    req_n = 3'b111;
    step();
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req_n = 3'b000;
    for (int r = 0; r < 3; r++) begin
      step();
      if (obs_fp !== 8'b110_00_100) begin
        errs++; $display("FAIL fp_grant[%0d]: got %b exp %b", r, obs_fp, 8'b110_00_100);
      end
      vec++;
      frame_n = 1'b0;
      irdy_n  = 1'b0;
      step();
      if (obs_fp !== 8'b110_00_110) begin
        errs++; $display("FAIL fp_busy[%0d]: got %b exp %b", r, obs_fp, 8'b110_00_110);
      end
      vec++;
      frame_n = 1'b1;
      irdy_n  = 1'b1;
      step();
      if (obs_fp !== 8'b111_00_000) begin
        errs++; $display("FAIL fp_turn[%0d]: got %b exp %b", r, obs_fp, 8'b111_00_000);
      end
      vec++;
    end
    req_n = 3'b111;
    step();
  endtask

  task automatic test_back_to_back();
    do_reset();
    req_n = 3'b101;
    step();
    if (obs !== 8'b101_01_100) begin
      errs++; $display("FAIL b2b_grant: got %b exp %b", obs, 8'b101_01_100);
    end
    vec++;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    step();
    if (obs !== 8'b101_01_100) begin
      errs++; $display("FAIL b2b_regrant: got %b exp %b", obs, 8'b101_01_100);
    end
    vec++;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    req_n   = 3'b111;
    step();
    if (obs !== 8'b111_01_000) begin
      errs++; $display("FAIL b2b_release: got %b exp %b", obs, 8'b111_01_000);
    end
    vec++;
  endtask

  task automatic test_timeout();
    do_reset();
    req_n = 3'b101;
    step();
    if (obs !== 8'b101_01_100) begin
      errs++; $display("FAIL tmo_grant_c1: got %b exp %b", obs, 8'b101_01_100);
    end
    vec++;
    for (int c = 2; c <= 16; c++) begin
      if (c == 10) req_n = 3'b001;
      step();
      if (obs !== 8'b101_01_100) begin
        errs++; $display("FAIL tmo_hold_c%0d: got %b exp %b", c, obs, 8'b101_01_100);
      end
      vec++;
    end
    step();
    if (obs !== 8'b111_01_001) begin
      errs++; $display("FAIL tmo_pulse: got %b exp %b", obs, 8'b111_01_001);
    end
    vec++;
    step();
    if (obs !== 8'b011_10_100) begin
      errs++; $display("FAIL tmo_next_owner: got %b exp %b", obs, 8'b011_10_100);
    end
    vec++;
    req_n = 3'b111;
    step();
    if (obs !== 8'b111_10_000) begin
      errs++; $display("FAIL grant_release_idle: got %b exp %b", obs, 8'b111_10_000);
    end
    vec++;
  endtask

  task automatic test_async_reset();
    do_reset();
    req_n = 3'b101;
    step();
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    step();
    if (obs !== 8'b101_01_110) begin
      errs++; $display("FAIL arst_pre_busy: got %b exp %b", obs, 8'b101_01_110);
    end
    vec++;
    #3;
    RESET = 1'b0;
    #1;
    if (obs !== 8'b111_00_000) begin
      errs++; $display("FAIL arst_drop: got %b exp %b", obs, 8'b111_00_000);
    end
    vec++;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    req_n   = 3'b111;
    step();
    RESET = 1'b1;
    req_n = 3'b000;
    step();
    if (obs !== 8'b110_00_100) begin
      errs++; $display("FAIL arst_rr_restart: got %b exp %b", obs, 8'b110_00_100);
    end
    vec++;
    req_n = 3'b111;
    step();
  endtask

  task automatic test_park();
    do_reset();
    step();
    if (obs !== 8'b110_00_100) begin
      errs++; $display("FAIL park_m0: got %b exp %b", obs, 8'b110_00_100);
    end
    vec++;
    req_n = 3'b011;
    step();
    if (obs !== 8'b111_00_000) begin
      errs++; $display("FAIL park_turn1: got %b exp %b", obs, 8'b111_00_000);
    end
    vec++;
    step();
    if (obs !== 8'b011_10_100) begin
      errs++; $display("FAIL park_grant2: got %b exp %b", obs, 8'b011_10_100);
    end
    vec++;
    frame_n = 1'b0;
    irdy_n  = 1'b0;
    step();
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    req_n   = 3'b111;
    step();
    step();
    if (obs !== 8'b011_10_100) begin
      errs++; $display("FAIL park_on_last: got %b exp %b", obs, 8'b011_10_100);
    end
    vec++;
    repeat (20) step();
    if (obs !== 8'b011_10_100) begin
      errs++; $display("FAIL park_no_timeout: got %b exp %b", obs, 8'b011_10_100);
    end
    vec++;
    frame_n = 1'b0;
    step();
    if (obs !== 8'b011_10_110) begin
      errs++; $display("FAIL park_frame_busy: got %b exp %b", obs, 8'b011_10_110);
    end
    vec++;
    frame_n = 1'b1;
    step();
    step();
    req_n = 3'b110;
    step();
    if (obs !== 8'b111_10_000) begin
      errs++; $display("FAIL park_turn2: got %b exp %b", obs, 8'b111_10_000);
    end
    vec++;
    step();
    if (obs !== 8'b110_00_100) begin
      errs++; $display("FAIL park_grant0: got %b exp %b", obs, 8'b110_00_100);
    end
    vec++;
  endtask

  initial begin
    RESET   = 1'b0;
    req_n   = 3'b111;
    frame_n = 1'b1;
    irdy_n  = 1'b1;
    test_reset();
`ifdef PCI_ARB_PARK_EN
    test_park();
`else
    test_single();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back();
    test_timeout();
    test_async_reset();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

`default_nettype wire
